// File: rtl/cv32e40x_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// cv32e40x_redirect_ctrl
//
// Control-transfer redirect unit placed after the ID-stage PC target adder.
// Turns ID jumps (and, optionally, predicted-taken branches) into registered
// redirect requests for the prefetcher, tracks the branch that moved into EX
// and, when EX resolves it against the prediction, issues the corrective
// redirect, flushes ID and counts the mispredict.
//
// Configuration macro:
//   CV32E40X_BCH_PREDICT_EN  defined   : bch_prediction_id_i is used, taken
//                                         predictions redirect from ID.
//                            undefined : static not-taken, prediction input
//                                         ignored.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   kill_i                controller flush, cancels pending request + tracker
//   jmp_id_i/jmp_target_i JAL/JALR in ID and its target
//   bch_id_i/bch_target_i conditional branch in ID and its target
//   bch_prediction_id_i   1 = predict taken
//   pc_next_id_i          fall-through address of the ID instruction
//   id_ex_advance_i       ID instruction moves to EX this cycle
//   bch_resolve_ex_i      branch in EX resolves, outcome on bch_taken_ex_i
//   redirect_req_o/_addr_o/_ack_i  req/ack handshake to the prefetcher
//   flush_id_o            combinational kill of the ID instruction
//   mispredict_o          registered one-cycle mispredict pulse
//   mispredict_cnt_o      saturating mispredict counter
// ---------------------------------------------------------------------------
module cv32e40x_redirect_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             kill_i,
  input  logic             jmp_id_i,
  input  logic [31:0]      jmp_target_i,
  input  logic             bch_id_i,
  input  logic [31:0]      bch_target_i,
  input  logic             bch_prediction_id_i,
  input  logic [31:0]      pc_next_id_i,
  input  logic             id_ex_advance_i,
  input  logic             bch_resolve_ex_i,
  input  logic             bch_taken_ex_i,
  output logic             redirect_req_o,
  output logic [31:0]      redirect_addr_o,
  input  logic             redirect_ack_i,
  output logic             flush_id_o,
  output logic             mispredict_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic               mis_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bt_valid_q, bt_valid_d;
  logic               bt_pred_q, bt_pred_d;
  logic [31:0]        bt_alt_q, bt_alt_d;

  logic               pred_eff;
  logic               mis_det;
  logic               id_trig;
  logic [31:0]        id_addr;
  logic               bt_load;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [31:0] hw_align(input logic [31:0] a);
    return {a[31:1], 1'b0};
  endfunction

`ifdef CV32E40X_BCH_PREDICT_EN
  assign pred_eff = bch_prediction_id_i;
`else
  // Static not-taken: the prediction input is deliberately left dangling.
  logic unused_prediction;
  assign unused_prediction = bch_prediction_id_i;
  assign pred_eff          = 1'b0;
`endif

  always_comb begin
    // kill_i outranks the mispredict path.
    mis_det = ~kill_i & bch_resolve_ex_i & bt_valid_q & (bch_taken_ex_i != bt_pred_q);
    id_trig = id_ex_advance_i & (jmp_id_i | (bch_id_i & pred_eff));
    id_addr = jmp_id_i ? jmp_target_i : bch_target_i;

    state_d = state_q;
    addr_d  = addr_q;
    if (kill_i) begin
      state_d = IDLE;
    end else if (mis_det) begin
      // Overrides a pending ID redirect and drops a same-cycle ID trigger.
      state_d = REQ;
      addr_d  = hw_align(bt_alt_q);
    end else if (id_trig && (state_q == IDLE || redirect_ack_i)) begin
      // Accepted in the ack cycle too, giving back-to-back requests.
      state_d = REQ;
      addr_d  = hw_align(id_addr);
    end else if (state_q == REQ && redirect_ack_i) begin
      state_d = IDLE;
    end

    cnt_d = mis_det ? sat_inc(cnt_q) : cnt_q;

    // A branch in ID that is flushed by a mispredict never reaches EX.
    bt_load    = id_ex_advance_i & bch_id_i & ~mis_det;
    bt_valid_d = bt_valid_q;
    bt_pred_d  = bt_pred_q;
    bt_alt_d   = bt_alt_q;
    if (kill_i) begin
      bt_valid_d = 1'b0;
    end else if (bt_load) begin
      bt_valid_d = 1'b1;
      bt_pred_d  = pred_eff;
      bt_alt_d   = pred_eff ? pc_next_id_i : bch_target_i;
    end else if (bch_resolve_ex_i) begin
      bt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= 32'h0;
      mis_q      <= 1'b0;
      cnt_q      <= '0;
      bt_valid_q <= 1'b0;
      bt_pred_q  <= 1'b0;
      bt_alt_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mis_q      <= mis_det;
      cnt_q      <= cnt_d;
      bt_valid_q <= bt_valid_d;
      bt_pred_q  <= bt_pred_d;
      bt_alt_q   <= bt_alt_d;
    end
  end

  assign redirect_req_o   = (state_q == REQ);
  assign redirect_addr_o  = addr_q;
  assign flush_id_o       = mis_det;
  assign mispredict_o     = mis_q;
  assign mispredict_cnt_o = cnt_q;

endmodule

// File: tb/tb_cv32e40x_redirect_ctrl.sv
module tb_cv32e40x_redirect_ctrl;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef CV32E40X_BCH_PREDICT_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          kill_i, jmp_id_i, bch_id_i, bch_prediction_id_i;
  logic [31:0]   jmp_target_i, bch_target_i, pc_next_id_i;
  logic          id_ex_advance_i, bch_resolve_ex_i, bch_taken_ex_i;
  logic          redirect_req_o, redirect_ack_i, flush_id_o, mispredict_o;
  logic [31:0]   redirect_addr_o;
  logic [CW-1:0] mispredict_cnt_o;

  always #5 clk = ~clk;

  cv32e40x_redirect_ctrl #(.CNT_W(CW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .kill_i              (kill_i),
    .jmp_id_i            (jmp_id_i),
    .jmp_target_i        (jmp_target_i),
    .bch_id_i            (bch_id_i),
    .bch_target_i        (bch_target_i),
    .bch_prediction_id_i (bch_prediction_id_i),
    .pc_next_id_i        (pc_next_id_i),
    .id_ex_advance_i     (id_ex_advance_i),
    .bch_resolve_ex_i    (bch_resolve_ex_i),
    .bch_taken_ex_i      (bch_taken_ex_i),
    .redirect_req_o      (redirect_req_o),
    .redirect_addr_o     (redirect_addr_o),
    .redirect_ack_i      (redirect_ack_i),
    .flush_id_o          (flush_id_o),
    .mispredict_o        (mispredict_o),
    .mispredict_cnt_o    (mispredict_cnt_o)
  );

  typedef struct packed {
    logic        kill;
    logic        jmp;
    logic [31:0] jt;
    logic        bch;
    logic [31:0] bt;
    logic        pred;
    logic [31:0] pn;
    logic        adv;
    logic        res;
    logic        tk;
    logic        ack;
  } stim_t;

  typedef struct packed {
    logic          req;
    logic [31:0]   addr;
    logic          mis;
    logic [CW-1:0] cnt;
    logic          flush;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: one pending redirect slot, one tracked branch, a counter.
  bit          m_pending;
  logic [31:0] m_target;
  bit          m_pulse;
  int          m_count;
  bit          m_br_live, m_br_guess;
  logic [31:0] m_br_other;

  task automatic model_reset();
    m_pending  = 0;
    m_target   = 32'h0;
    m_pulse    = 0;
    m_count    = 0;
    m_br_live  = 0;
    m_br_guess = 0;
    m_br_other = 32'h0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    kill_i              = s.kill;
    jmp_id_i            = s.jmp;
    jmp_target_i        = s.jt;
    bch_id_i            = s.bch;
    bch_target_i        = s.bt;
    bch_prediction_id_i = s.pred;
    pc_next_id_i        = s.pn;
    id_ex_advance_i     = s.adv;
    bch_resolve_ex_i    = s.res;
    bch_taken_ex_i      = s.tk;
    redirect_ack_i      = s.ack;
  endtask

  // One clock cycle: drive inputs, queue what the DUT must show this cycle,
  // then move the model across the clock edge.
  task automatic step(input stim_t s);
    exp_t e;
    bit   wrong, guess, wants;
    @(posedge clk);
    #1;
    drive(s);
    wrong = !s.kill && s.res && m_br_live && (s.tk != m_br_guess);
    e.req   = m_pending;
    e.addr  = m_target;
    e.mis   = m_pulse;
    e.cnt   = CW'(m_count);
    e.flush = wrong;
    sbq.push_back(e);

    guess = PE && s.pred;
    wants = s.adv && (s.jmp || (s.bch && guess));
    if (s.kill) begin
      m_pending = 0;
    end else if (wrong) begin
      m_pending = 1;
      m_target  = m_br_other & ~32'h1;
    end else if (wants && (!m_pending || s.ack)) begin
      m_pending = 1;
      m_target  = (s.jmp ? s.jt : s.bt) & ~32'h1;
    end else if (m_pending && s.ack) begin
      m_pending = 0;
    end
    m_pulse = wrong;
    if (wrong && m_count < CMAX) m_count++;

    if (s.kill) m_br_live = 0;
    else if (s.adv && s.bch && !wrong) begin
      m_br_live  = 1;
      m_br_guess = guess;
      m_br_other = guess ? s.pn : s.bt;
    end else if (s.res) m_br_live = 0;
  endtask

  // Monitor: pop the expectation for this cycle and compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("redirect_req", {31'b0, redirect_req_o}, {31'b0, e.req});
        if (e.req) chk("redirect_addr", redirect_addr_o, e.addr);
        chk("mispredict", {31'b0, mispredict_o}, {31'b0, e.mis});
        chk("mispredict_cnt", {28'b0, mispredict_cnt_o}, {28'b0, e.cnt});
        chk("flush_id", {31'b0, flush_id_o}, {31'b0, e.flush});
        chk("no_id_trigger_while_req",
            {31'b0, redirect_req_o && !redirect_ack_i && id_ex_advance_i &&
                    (jmp_id_i || (bch_id_i && PE && bch_prediction_id_i))},
            32'h0);
      end
    end
  end

  initial begin
    stim_t s;
    int    r;
    model_reset();
    rst_n = 1'b0;
    drive('0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    step('0);

    // Jump with ack held off for three cycles
    s = '0; s.adv = 1; s.jmp = 1; s.jt = 32'h0000_1000; step(s);
    repeat (3) step('0);
    s = '0; s.ack = 1; step(s);
    step('0);
    step('0);

    // Backward / forward branch pair: pred=1, resolves not-taken
    s = '0; s.adv = 1; s.bch = 1; s.bt = 32'h0FF0; s.pred = 1; s.pn = 32'h1004; step(s);
    s = '0; s.res = 1; s.tk = 0; step(s);
    s = '0; s.ack = 1; step(s);
    s = '0; s.ack = 1; step(s);
    step('0);

    // Branch (pred=1) resolves taken
    s = '0; s.adv = 1; s.bch = 1; s.bt = 32'h2000; s.pred = 1; s.pn = 32'h1804; step(s);
    s = '0; s.res = 1; s.tk = 1; step(s);
    s = '0; s.ack = 1; step(s);
    s = '0; s.ack = 1; step(s);
    step('0);

    // Override: jump to 0x3000 pending, tracked branch mispredicts to 0x4000
    s = '0; s.adv = 1; s.bch = 1; s.bt = 32'h4000; s.pn = 32'h2204; step(s);
    s = '0; s.adv = 1; s.jmp = 1; s.jt = 32'h3000; step(s);
    s = '0; s.res = 1; s.tk = 1; step(s);
    step('0);
    s = '0; s.ack = 1; step(s);
    step('0);
    step('0);

    // kill during REQ with a live tracked branch
    s = '0; s.adv = 1; s.bch = 1; s.bt = 32'h6000; s.pn = 32'h5004; step(s);
    s = '0; s.adv = 1; s.jmp = 1; s.jt = 32'h7000; step(s);
    s = '0; s.kill = 1; step(s);
    s = '0; s.res = 1; s.tk = 1; step(s);
    step('0);
    step('0);

    // Saturation: 17 mispredicts
    for (int i = 0; i < 17; i++) begin
      s = '0; s.adv = 1; s.ack = 1; s.bch = 1; s.bt = 32'h8000 + 32'(i * 16) + 32'h1;
      s.pn = 32'h9000; step(s);
      s = '0; s.res = 1; s.tk = 1; s.ack = 1; step(s);
    end
    s = '0; s.ack = 1; step(s);
    step('0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s      = '0;
      s.ack  = ($urandom_range(0, 1) == 1);
      s.kill = ($urandom_range(0, 15) == 0);
      r      = $urandom_range(0, 3);
      s.jmp  = (r == 0);
      s.bch  = (r == 1);
      s.jt   = $urandom;
      s.bt   = $urandom;
      s.pn   = $urandom;
      s.pred = ($urandom_range(0, 1) == 1);
      s.adv  = (!m_pending || s.ack) ? ($urandom_range(0, 1) == 1) : 1'b0;
      s.res  = ($urandom_range(0, 2) == 0);
      s.tk   = ($urandom_range(0, 1) == 1);
      step(s);
    end

    // Asynchronous reset in the middle of a request
    s = '0; s.adv = 1; s.ack = 1; s.jmp = 1; s.jt = 32'hA000; step(s);
    @(negedge clk);
    @(posedge clk);
    #1;
    drive('0);
    chk("req_before_async_reset", {31'b0, redirect_req_o}, {31'b0, m_pending});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'b0, redirect_req_o}, 32'h0);
    chk("async_rst_addr", redirect_addr_o, 32'h0);
    chk("async_rst_flush", {31'b0, flush_id_o}, 32'h0);
    chk("async_rst_mispredict", {31'b0, mispredict_o}, 32'h0);
    chk("async_rst_cnt", {28'b0, mispredict_cnt_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) step('0);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv32e40x_redirect_ctrl.md
# cv32e40x_redirect_ctrl

Sequential control-transfer redirect unit sitting directly downstream of the ID-stage PC target adder. It consumes the jump/branch targets and the ID-stage branch prediction, issues registered redirect requests to the prefetch unit over a req/ack handshake, and tracks each predicted branch into EX. When EX resolves the branch, it detects mispredictions, issues the corrective redirect and flushes ID.

## Interface
Parameters:
- CNT_W, 16, width of the saturating mispredict counter

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- kill_i  in  1  controller flush (exception/debug); cancels all pending state
- jmp_id_i  in  1  JAL/JALR valid in ID this cycle
- jmp_target_i  in  32  jump target from PC target adder
- bch_id_i  in  1  conditional branch valid in ID this cycle
- bch_target_i  in  32  branch target from PC target adder
- bch_prediction_id_i  in  1  1 = predict taken (backward branch)
- pc_next_id_i  in  32  fall-through address of the ID instruction
- id_ex_advance_i  in  1  ID instruction moves to EX this cycle
- bch_resolve_ex_i  in  1  branch in EX resolves this cycle
- bch_taken_ex_i  in  1  resolved outcome, qualified by bch_resolve_ex_i
- redirect_req_o  out  1  redirect request to prefetcher
- redirect_addr_o  out  32  redirect address, halfword aligned (bit 0 forced 0)
- redirect_ack_i  in  1  prefetcher accepts redirect
- flush_id_o  out  1  kill instruction currently in ID
- mispredict_o  out  1  one-cycle pulse on detected misprediction
- mispredict_cnt_o  out  CNT_W  saturating mispredict count

## Operation
- FSM states: IDLE, REQ. IDLE→REQ on any redirect trigger. REQ→IDLE on redirect_ack_i with no new trigger in the same cycle. kill_i forces IDLE from any state.
- ID triggers, sampled only when id_ex_advance_i=1:
  - jmp_id_i → redirect to jmp_target_i.
  - bch_id_i with an effective prediction of taken → redirect to bch_target_i.
- Branch tracker, loaded on id_ex_advance_i & bch_id_i:
  - bt_valid ← 1.
  - bt_pred ← effective prediction.
  - bt_alt ← the address not chosen: pc_next_id_i if predicted taken, else bch_target_i.
  - bt_valid clears on bch_resolve_ex_i or kill_i.
- EX resolve with bch_taken_ex_i != bt_pred is a mispredict. Effects:
  - Redirect to bt_alt.
  - flush_id_o=1 in the same cycle (combinational).
  - mispredict_o pulse.
  - Counter +1, saturating at all-ones.
- Priority: kill_i > EX mispredict > ID trigger.
  - A mispredict in the same cycle as an ID trigger drops the ID trigger. The ID instruction is flushed.
  - A mispredict while in REQ replaces redirect_addr_o. This is the only permitted change of address while a request is pending.
  - An ID trigger while in REQ is impossible by construction, because ID is stalled (id_ex_advance_i=0) while in REQ. This is asserted in the bench.
- bch_resolve_ex_i with bt_valid=0 is ignored.

## Timing
- Reset values:
  - redirect_req_o=0
  - redirect_addr_o=32'h0
  - flush_id_o=0
  - mispredict_o=0
  - mispredict_cnt_o=0
  - FSM=IDLE, bt_valid=0
- Latency: a trigger in cycle N produces registered redirect_req_o and redirect_addr_o in cycle N+1.
- Handshake: redirect_req_o stays high until it is sampled together with redirect_ack_i. The transfer completes in that cycle, and req is low in the next cycle unless a new trigger occurred.
- Back-to-back: a trigger in the ack cycle keeps req high and loads the new address. There are no bubble cycles.
- mispredict_o is registered and pulses in cycle N+1, aligned with the new request.
- kill_i: req drops in the next cycle, and the pending address is discarded. The counter is not reset by kill_i.
- Asynchronous reset mid-request: all outputs return to reset values immediately.

## Configuration
- CV32E40X_BCH_PREDICT_EN defined:
  - Effective prediction = bch_prediction_id_i.
  - A taken prediction redirects from ID.
- Not defined:
  - Effective prediction is forced to 0 (static not-taken).
  - bch_prediction_id_i is ignored.
  - No ID branch redirects occur. Taken branches redirect only via the EX mispredict path.

## Test plan
- Jump: jmp_id_i=1, jmp_target_i=32'h0000_1000, advance=1 in cycle 0. Required: req=1 and addr=32'h1000 in cycle 1. Ack held off for 3 cycles → addr stable throughout. Ack in cycle 4 → req=0 in cycle 5.
- Backward branch with PREDICT_EN: bch_target=32'h0FF0, pred=1, pc_next=32'h1004. Required: redirect to 32'h0FF0. EX resolves not-taken → flush_id_o=1 the same cycle, redirect to 32'h1004 in the next cycle, mispredict_o pulse, counter=1.
- Branch predicted not-taken: bch_target=32'h2000. EX resolves taken → redirect to 32'h2000 and a mispredict is counted. With the macro undefined, a pred=1 input shows identical behaviour.
- Override: ID redirect pending to 32'h3000, unacked, when an EX mispredict to 32'h4000 occurs. Required: addr becomes 32'h4000 in the next cycle, and exactly one ack completes the transfer.
- kill_i during REQ with bt_valid=1. Required: req=0 in the next cycle. A subsequent bch_resolve_ex_i causes no mispredict and the counter is unchanged.
- Saturation, with CNT_W=4: 17 mispredicts → mispredict_cnt_o=4'hF. Reset asserted mid-request → all outputs 0 asynchronously.
